usb_stream_adapter: RTL and testbench

- Clock-domain-local bridge in the clk_100 domain, sitting between the FT601 CDC FIFOs (32-bit words plus byte enables) and command_processor's byte-wide command input and 32-bit keep/last response output.
- Unpacks host words into command bytes, LSB first, honouring byte enables.
- Buffers command_processor response beats in a small FIFO and presents them as FT601 TX words with a packet-end flag.
- Fills the currently stubbed USB i_t*/o_t* connections.

---
 rtl/usb_stream_adapter_if.sv | 41 ++++
 rtl/usb_stream_adapter.sv | 131 +++++++++++++
 tb/tb_usb_stream_adapter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_stream_adapter_if.sv
// Handshake bundle between the FT601 CDC FIFOs, command_processor and usb_stream_adapter.
// The slave modport is the adapter's view; master is the surrounding environment.
interface usb_stream_adapter_if #(
  parameter int TX_AW = 4
);
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       rx_data;
  logic [3:0]        rx_be;

  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [7:0]        cmd_tdata;

  logic              rsp_tvalid;
  logic              rsp_tready;
  logic [31:0]       rsp_tdata;
  logic [3:0]        rsp_tkeep;
  logic              rsp_tlast;

  logic              tx_valid;
  logic              tx_ready;
  logic [31:0]       tx_data;
  logic [3:0]        tx_be;
  logic              tx_last;
  logic [TX_AW:0]    tx_level;

  modport slave (
    input  rx_valid, rx_data, rx_be, cmd_tready,
           rsp_tvalid, rsp_tdata, rsp_tkeep, rsp_tlast, tx_ready,
    output rx_ready, cmd_tvalid, cmd_tdata, rsp_tready,
           tx_valid, tx_data, tx_be, tx_last, tx_level
  );

  modport master (
    output rx_valid, rx_data, rx_be, cmd_tready,
           rsp_tvalid, rsp_tdata, rsp_tkeep, rsp_tlast, tx_ready,
    input  rx_ready, cmd_tvalid, cmd_tdata, rsp_tready,
           tx_valid, tx_data, tx_be, tx_last, tx_level
  );
endinterface

// File: rtl/usb_stream_adapter.sv
// FT601 word <-> command_processor byte/beat bridge: RX word unpacker plus show-ahead TX response FIFO.
// Optional statistics counters are enabled with `define USB_ADAPTER_STATS_EN.
module usb_stream_adapter #(
  parameter int TX_FIFO_DEPTH = 16,
  parameter int TX_AW         = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  usb_stream_adapter_if.slave  bus
`ifdef USB_ADAPTER_STATS_EN
  ,
  output logic [31:0]          stat_rx_bytes,
  output logic [31:0]          stat_tx_pkts,
  output logic [15:0]          stat_tx_ovf_stall
`endif
);

  typedef enum logic {IDLE, HOLD} rx_state_e;

  localparam logic [TX_AW:0] DEPTH = (TX_AW+1)'(TX_FIFO_DEPTH);

  // Byte at the lowest enabled lane; lanes are emitted in ascending order.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [3:0] m);
    if (m[0])      return w[7:0];
    else if (m[1]) return w[15:8];
    else if (m[2]) return w[23:16];
    else           return w[31:24];
  endfunction

  // ---------------- RX unpacker ----------------
  rx_state_e   state;
  logic [31:0] word;
  logic [3:0]  mask;
  logic        started;
  logic [3:0]  mask_rest;
  logic        last_byte;
  logic        cmd_fire;
  logic        rx_load;

  assign mask_rest = mask & (mask - 4'd1);
  assign last_byte = (mask_rest == 4'd0);
  assign cmd_fire  = bus.cmd_tvalid && bus.cmd_tready;

  // Ready combinationally on the final byte's handshake so the next word loads without a bubble.
  assign bus.rx_ready = started && ((state == IDLE) || (state == HOLD && cmd_fire && last_byte));
  assign rx_load      = bus.rx_valid && bus.rx_ready && (bus.rx_be != 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      word           <= '0;
      mask           <= '0;
      started        <= 1'b0;
      bus.cmd_tvalid <= 1'b0;
      bus.cmd_tdata  <= '0;
    end else begin
      started <= 1'b1;
      if (rx_load) begin
        state          <= HOLD;
        word           <= bus.rx_data;
        mask           <= bus.rx_be;
        bus.cmd_tvalid <= 1'b1;
        bus.cmd_tdata  <= pick_byte(bus.rx_data, bus.rx_be);
      end else if (cmd_fire) begin
        if (last_byte) begin
          state          <= IDLE;
          mask           <= '0;
          bus.cmd_tvalid <= 1'b0;
          bus.cmd_tdata  <= '0;
        end else begin
          mask          <= mask_rest;
          bus.cmd_tdata <= pick_byte(word, mask_rest);
        end
      end
    end
  end

  // ---------------- TX response FIFO ----------------
  logic [36:0]    mem [TX_FIFO_DEPTH];
  logic [TX_AW:0] wr_ptr;
  logic [TX_AW:0] rd_ptr;
  logic [TX_AW:0] level;
  logic [36:0]    head;
  logic           push;
  logic           pop;

  assign level          = wr_ptr - rd_ptr;
  assign bus.rsp_tready = started && (level != DEPTH);
  // Empty non-last beats are accepted but never stored; empty last beats become zero-length markers.
  assign push           = bus.rsp_tvalid && bus.rsp_tready && ((bus.rsp_tkeep != 4'd0) || bus.rsp_tlast);
  assign bus.tx_valid   = (level != '0);
  assign pop            = bus.tx_valid && bus.tx_ready;
  assign head           = mem[rd_ptr[TX_AW-1:0]];

  assign bus.tx_data  = bus.tx_valid ? head[31:0]  : '0;
  assign bus.tx_be    = bus.tx_valid ? head[35:32] : '0;
  assign bus.tx_last  = bus.tx_valid ? head[36]    : 1'b0;
  assign bus.tx_level = level;

  // NOTE: storage is deliberately not reset; entries are only visible through tx_valid, which the pointers gate.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[TX_AW-1:0]] <= {bus.rsp_tlast, bus.rsp_tkeep, bus.rsp_tdata};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef USB_ADAPTER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_rx_bytes     <= '0;
      stat_tx_pkts      <= '0;
      stat_tx_ovf_stall <= '0;
    end else begin
      if (cmd_fire)                stat_rx_bytes <= stat_rx_bytes + 32'd1;
      if (pop && bus.tx_last)      stat_tx_pkts  <= stat_tx_pkts + 32'd1;
      if (bus.rsp_tvalid && !bus.rsp_tready && (stat_tx_ovf_stall != 16'hFFFF))
        stat_tx_ovf_stall <= stat_tx_ovf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_stream_adapter.sv
// Directed + randomized bench for usb_stream_adapter, scored against a queue-based reference model.
module tb_usb_stream_adapter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  usb_stream_adapter_if #(.TX_AW(4)) bus ();

`ifdef USB_ADAPTER_STATS_EN
  logic [31:0] stat_rx_bytes;
  logic [31:0] stat_tx_pkts;
  logic [15:0] stat_tx_ovf_stall;
`endif

  usb_stream_adapter #(.TX_FIFO_DEPTH(16), .TX_AW(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef USB_ADAPTER_STATS_EN
    ,
    .stat_rx_bytes     (stat_rx_bytes),
    .stat_tx_pkts      (stat_tx_pkts),
    .stat_tx_ovf_stall (stat_tx_ovf_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes owed to command_processor, words owed to the TX FIFO.
  logic [7:0]  exp_bytes [$];
  logic [36:0] exp_tx    [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes mid-cycle, update the model, then advance one clock.
  task automatic tick();
    logic [36:0] e;
    @(negedge clk);
    check("tx_level", 64'(bus.tx_level), 64'(exp_tx.size()));
    check("tx_valid", 64'(bus.tx_valid), 64'(exp_tx.size() != 0));
    if (bus.rx_valid && bus.rx_ready)
      for (int b = 0; b < 4; b++)
        if (bus.rx_be[b]) exp_bytes.push_back(bus.rx_data[8*b +: 8]);
    if (bus.cmd_tvalid && bus.cmd_tready) begin
      if (exp_bytes.size() == 0) check("cmd_unexpected_byte", 64'(bus.cmd_tdata), 64'hFFFF_FFFF);
      else                       check("cmd_byte", 64'(bus.cmd_tdata), 64'(exp_bytes.pop_front()));
    end
    if (bus.tx_valid && bus.tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected_word", 64'(bus.tx_data), 64'hFFFF_FFFF_FFFF);
      else begin
        e = exp_tx.pop_front();
        check("tx_word", 64'({bus.tx_last, bus.tx_be, bus.tx_data}), 64'(e));
      end
    end
    if (bus.rsp_tvalid && bus.rsp_tready && ((bus.rsp_tkeep != 4'd0) || bus.rsp_tlast))
      exp_tx.push_back({bus.rsp_tlast, bus.rsp_tkeep, bus.rsp_tdata});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},   64'(bus.rx_ready),   64'd0);
    check({tag, "_cmd_tvalid"}, 64'(bus.cmd_tvalid), 64'd0);
    check({tag, "_cmd_tdata"},  64'(bus.cmd_tdata),  64'd0);
    check({tag, "_rsp_tready"}, 64'(bus.rsp_tready), 64'd0);
    check({tag, "_tx_valid"},   64'(bus.tx_valid),   64'd0);
    check({tag, "_tx_data"},    64'(bus.tx_data),    64'd0);
    check({tag, "_tx_be"},      64'(bus.tx_be),      64'd0);
    check({tag, "_tx_last"},    64'(bus.tx_last),    64'd0);
    check({tag, "_tx_level"},   64'(bus.tx_level),   64'd0);
`ifdef USB_ADAPTER_STATS_EN
    check({tag, "_stat_rx"},    64'(stat_rx_bytes),     64'd0);
    check({tag, "_stat_pkts"},  64'(stat_tx_pkts),      64'd0);
    check({tag, "_stat_ovf"},   64'(stat_tx_ovf_stall), 64'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  seq_a [4]     = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic        stall_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]  stall_exp [6] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
    logic [31:0] beat_data [20];
    logic [3:0]  beat_keep [20];
    logic        acc;
    int          beat;

    bus.rx_valid = 0; bus.rx_data = '0; bus.rx_be = '0; bus.cmd_tready = 0;
    bus.rsp_tvalid = 0; bus.rsp_tdata = '0; bus.rsp_tkeep = '0; bus.rsp_tlast = 0;
    bus.tx_ready = 0;

    // Reset values, then the one-cycle ready holdoff after release.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    check("first_cycle_rx_ready",  64'(bus.rx_ready),   64'd0);
    check("first_cycle_rsp_tready", 64'(bus.rsp_tready), 64'd0);
    tick();
    check("rx_ready_after_release",  64'(bus.rx_ready),   64'd1);
    check("rsp_tready_after_release", 64'(bus.rsp_tready), 64'd1);

    // Full word, LSB first, one byte per cycle.
    bus.cmd_tready = 1; bus.rx_valid = 1; bus.rx_data = 32'h4433_2211; bus.rx_be = 4'hF;
    tick();
    bus.rx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      check("w1_tvalid",   64'(bus.cmd_tvalid), 64'd1);
      check("w1_tdata",    64'(bus.cmd_tdata),  64'(seq_a[i]));
      check("w1_rx_ready", 64'(bus.rx_ready),   64'(i == 3));
      tick();
    end
    check("w1_idle", 64'(bus.cmd_tvalid), 64'd0);

    // Back-to-back sparse words and a be=0 word, no bubbles.
    bus.rx_valid = 1; bus.rx_data = 32'hAABB_CCDD; bus.rx_be = 4'h5;
    tick();
    bus.rx_data = 32'h0000_0099; bus.rx_be = 4'h1;
    check("b2b_dd",       64'(bus.cmd_tdata), 64'hDD);
    check("b2b_ready_dd", 64'(bus.rx_ready),  64'd0);
    tick();
    check("b2b_bb",       64'(bus.cmd_tdata), 64'hBB);
    check("b2b_ready_bb", 64'(bus.rx_ready),  64'd1);
    tick();
    bus.rx_data = 32'h1234_5678; bus.rx_be = 4'h0;
    check("b2b_99_valid", 64'(bus.cmd_tvalid), 64'd1);
    check("b2b_99",       64'(bus.cmd_tdata),  64'h99);
    check("b2b_ready_99", 64'(bus.rx_ready),   64'd1);
    tick();
    bus.rx_valid = 0;
    check("be0_no_byte", 64'(bus.cmd_tvalid), 64'd0);
    tick();
    check("be0_still_idle", 64'(bus.cmd_tvalid), 64'd0);

    // Backpressure on cmd_tready holds the presented byte.
    bus.rx_valid = 1; bus.rx_data = 32'h4433_2211; bus.rx_be = 4'hF;
    tick();
    bus.rx_valid = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_tready = stall_pat[i];
      check("stall_tdata", 64'(bus.cmd_tdata), 64'(stall_exp[i]));
      tick();
    end
    bus.cmd_tready = 1;
    check("stall_done", 64'(bus.cmd_tvalid), 64'd0);

    // Fill the TX FIFO past its depth with the sink stalled, then drain.
    for (int i = 0; i < 20; i++) begin
      beat_data[i] = $urandom;
      beat_keep[i] = 4'($urandom_range(1, 15));
    end
    bus.tx_ready = 0;
    beat = 0;
    for (int c = 0; c < 30 && beat < 20; c++) begin
      bus.rsp_tvalid = 1; bus.rsp_tdata = beat_data[beat];
      bus.rsp_tkeep = beat_keep[beat]; bus.rsp_tlast = (beat == 19);
      acc = bus.rsp_tready;
      tick();
      if (acc) beat++;
    end
    check("fill_beats_accepted", 64'(beat),           64'd16);
    check("fill_level",          64'(bus.tx_level),   64'd16);
    check("fill_rsp_tready",     64'(bus.rsp_tready), 64'd0);
    bus.tx_ready = 1;
    for (int c = 0; c < 100 && (beat < 20 || exp_tx.size() != 0); c++) begin
      if (beat < 20) begin
        bus.rsp_tvalid = 1; bus.rsp_tdata = beat_data[beat];
        bus.rsp_tkeep = beat_keep[beat]; bus.rsp_tlast = (beat == 19);
      end else bus.rsp_tvalid = 0;
      acc = bus.rsp_tvalid && bus.rsp_tready;
      tick();
      if (acc) beat++;
    end
    bus.rsp_tvalid = 0;
    check("drain_beats_sent", 64'(beat),         64'd20);
    check("drain_empty",      64'(bus.tx_valid), 64'd0);

    // Zero-length marker is stored; empty non-last beat is dropped.
    bus.tx_ready = 0;
    bus.rsp_tvalid = 1; bus.rsp_tdata = $urandom; bus.rsp_tkeep = 4'h0; bus.rsp_tlast = 1;
    tick();
    bus.rsp_tvalid = 0;
    check("marker_valid", 64'(bus.tx_valid), 64'd1);
    check("marker_be",    64'(bus.tx_be),    64'd0);
    check("marker_last",  64'(bus.tx_last),  64'd1);
    check("marker_level", 64'(bus.tx_level), 64'd1);
    bus.rsp_tvalid = 1; bus.rsp_tdata = $urandom; bus.rsp_tkeep = 4'h0; bus.rsp_tlast = 0;
    tick();
    bus.rsp_tvalid = 0;
    check("drop_level", 64'(bus.tx_level), 64'd1);
    bus.tx_ready = 1;
    tick();
    check("marker_popped", 64'(bus.tx_valid), 64'd0);

    // Randomized traffic on both independent paths.
    for (int c = 0; c < 400; c++) begin
      bus.rx_valid   = 1'($urandom_range(0, 1));
      bus.rx_data    = $urandom;
      bus.rx_be      = 4'($urandom_range(0, 15));
      bus.cmd_tready = ($urandom_range(0, 3) != 0);
      bus.rsp_tvalid = 1'($urandom_range(0, 1));
      bus.rsp_tdata  = $urandom;
      bus.rsp_tkeep  = 4'($urandom_range(0, 15));
      bus.rsp_tlast  = ($urandom_range(0, 3) == 0);
      bus.tx_ready   = ($urandom_range(0, 2) == 0);
      tick();
    end
    bus.rx_valid = 0; bus.rsp_tvalid = 0; bus.cmd_tready = 1; bus.tx_ready = 1;
    repeat (40) tick();
    check("rand_bytes_delivered", 64'(exp_bytes.size()), 64'd0);
    check("rand_words_delivered", 64'(exp_tx.size()),    64'd0);
    check("rand_cmd_idle",        64'(bus.cmd_tvalid),   64'd0);

    // Reset mid-operation: HOLD with two bytes pending and five words queued.
    bus.tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.rsp_tvalid = 1; bus.rsp_tdata = $urandom; bus.rsp_tkeep = 4'hF; bus.rsp_tlast = (i == 4);
      tick();
    end
    bus.rsp_tvalid = 0;
    bus.rx_valid = 1; bus.rx_data = 32'h4433_2211; bus.rx_be = 4'hF;
    tick();
    bus.rx_valid = 0;
    tick();
    tick();
    bus.cmd_tready = 0;
    check("prereset_tdata", 64'(bus.cmd_tdata), 64'h33);
    check("prereset_level", 64'(bus.tx_level), 64'd5);
    rstn = 1'b0;
    exp_bytes.delete();
    exp_tx.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.cmd_tready = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("postreset_no_byte", 64'(bus.cmd_tvalid), 64'd0);
      tick();
    end
    check("postreset_level", 64'(bus.tx_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
